// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regwb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // One register-file write: destination and value
    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Writes to $zero are swallowed and never tracked
    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return r == ZERO_REG;
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Holding FIFO for long-latency results awaiting a write-back slot.
// Latency: a push at the end of cycle N is visible on head in cycle N+1.
// Backpressure: caller must not push when full nor pop when empty; no internal checks.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wr_req_t          push_dat,
    input  logic             pop,
    output wr_req_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage array: no reset needed, contents are only read when count says valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/regwb.sv
// Write-back arbiter owning the register-file write port, plus pending-destination scoreboard.
// Latency: selected write appears on regwrite/wrreg/wrdata next cycle; LU results +2 (+1 via bypass when REGWB_BYPASS_EN).
// Backpressure: lu_ready drops when the FIFO is full; pipe_stall holds the pipe write while a full FIFO drains.
module regwb
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic [31:0] pending,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wr_req_t          head;
    wr_req_t          lu_req;
    wr_req_t          sel;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             sel_vld;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             clr_vld;
    logic [4:0]       clr_reg;

    assign lu_req     = '{dst: lu_reg, data: lu_data};
    assign lu_ready   = (fifo_count != CNT_W'(DEPTH));
    assign pipe_stall = pipe_we && fifo_full;

    // Arbitration: a full FIFO drains first, then the pipe, then queued LU results
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        pop     = 1'b0;
        bypass  = 1'b0;
        if (fifo_full) begin
            sel     = head;
            sel_vld = 1'b1;
            pop     = 1'b1;
        end else if (pipe_we) begin
            sel     = '{dst: pipe_reg, data: pipe_data};
            sel_vld = 1'b1;
        end else if (!fifo_empty) begin
            sel     = head;
            sel_vld = 1'b1;
            pop     = 1'b1;
`ifdef REGWB_BYPASS_EN
        end else if (lu_valid) begin
            sel     = lu_req;
            sel_vld = 1'b1;
            bypass  = 1'b1;
`endif
        end
    end

    // A bypassed LU result never enters the FIFO; scoreboard clear follows whichever LU result is written
    always_comb begin
        push    = lu_valid && lu_ready && !bypass;
        clr_vld = pop || bypass;
        clr_reg = pop ? head.dst : lu_reg;
    end

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (lu_req),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Scoreboard: clear on LU write-back, set on issue; set is applied last so it wins a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_vld) pending[clr_reg] <= 1'b0;
            if (issue_valid && !is_zero_reg(issue_reg)) pending[issue_reg] <= 1'b1;
        end
    end

    // Output registers: $zero writes are consumed silently; address/data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wrreg    <= '0;
            wrdata   <= '0;
        end else begin
            regwrite <= sel_vld && !is_zero_reg(sel.dst);
            if (sel_vld && !is_zero_reg(sel.dst)) begin
                wrreg  <= sel.dst;
                wrdata <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_regwb.sv
// Self-checking bench for regwb: directed scenarios followed by constrained-random traffic.
// Reference is a queue-based model of the write-back rules evaluated once per cycle.
// Backpressure is exercised by filling the FIFO while the pipe writes continuously.
module tb_regwb;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [31:0] pending;
    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;

    regwb #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_reg    (pipe_reg),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_reg      (lu_reg),
        .lu_data     (lu_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .pending     (pending),
        .regwrite    (regwrite),
        .wrreg       (wrreg),
        .wrdata      (wrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pend;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        last_lu_acc;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        m_pend = '0;
        m_rw   = 1'b0;
        m_wr   = '0;
        m_wd   = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic step();
        logic e_ready;
        logic has;
        logic byp;
        ent_t w;
        #1;
        e_ready = (q.size() != DEPTH);
        chk("lu_ready", lu_ready, e_ready);
        chk("pipe_stall", pipe_stall, pipe_we && !e_ready);
        last_lu_acc = lu_valid && e_ready;
        last_stall  = pipe_we && !e_ready;
        has = 1'b0;
        byp = 1'b0;
        w   = '0;
        if (!e_ready) begin
            w = q.pop_front(); has = 1'b1; m_pend[w.r] = 1'b0;
        end else if (pipe_we) begin
            w = '{pipe_reg, pipe_data}; has = 1'b1;
        end else if (q.size() > 0) begin
            w = q.pop_front(); has = 1'b1; m_pend[w.r] = 1'b0;
`ifdef REGWB_BYPASS_EN
        end else if (lu_valid) begin
            w = '{lu_reg, lu_data}; has = 1'b1; byp = 1'b1; m_pend[lu_reg] = 1'b0;
`endif
        end
        if (lu_valid && e_ready && !byp) q.push_back('{lu_reg, lu_data});
        if (issue_valid && issue_reg != 5'd0) m_pend[issue_reg] = 1'b1;
        m_rw = has && (w.r != 5'd0);
        if (m_rw) begin
            m_wr = w.r;
            m_wd = w.d;
        end
        @(posedge clk);
        #1;
        chk("regwrite", regwrite, m_rw);
        chk("pending", pending, m_pend);
        if (m_rw) begin
            chk("wrreg", wrreg, m_wr);
            chk("wrdata", wrdata, m_wd);
        end
    endtask

    task automatic idle();
        pipe_we = 0; lu_valid = 0; issue_valid = 0;
        step();
    endtask

    int outst[$];
    int idx;
    int cand;
    logic do_issue;

    initial begin
        rst_n = 0; pipe_we = 0; pipe_reg = 0; pipe_data = 0;
        lu_valid = 0; lu_reg = 0; lu_data = 0; issue_valid = 0; issue_reg = 0;
        reset_model();
        last_stall = 0;

        // Reset held with random inputs: everything stays cleared
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'($urandom); pipe_reg = 5'($urandom); pipe_data = $urandom;
            lu_valid = 1'($urandom); lu_reg = 5'($urandom); lu_data = $urandom;
            issue_valid = 1'($urandom); issue_reg = 5'($urandom);
            @(posedge clk); #1;
            chk("rst_regwrite", regwrite, 0);
            chk("rst_wrreg", wrreg, 0);
            chk("rst_wrdata", wrdata, 0);
            chk("rst_pending", pending, 0);
            chk("rst_lu_ready", lu_ready, 1);
            chk("rst_pipe_stall", pipe_stall, 0);
        end
        pipe_we = 0; lu_valid = 0; issue_valid = 0;
        rst_n = 1;
        idle(); idle();

        // Single pipe write and its one-cycle pulse
        pipe_we = 1; pipe_reg = 8; pipe_data = 32'hDEADBEEF;
        step();
        chk("pipe8_rw", regwrite, 1);
        chk("pipe8_reg", wrreg, 8);
        chk("pipe8_data", wrdata, 32'hDEADBEEF);
        idle();
        chk("pipe8_done", regwrite, 0);

        // Issue then LU result for reg 9
        issue_valid = 1; issue_reg = 9;
        step();
        chk("pend9_set", pending[9], 1);
        issue_valid = 0; lu_valid = 1; lu_reg = 9; lu_data = 32'h1234;
        step();
`ifdef REGWB_BYPASS_EN
        chk("lu9_rw", regwrite, 1);
        chk("lu9_reg", wrreg, 9);
        chk("pend9_clr", pending[9], 0);
        idle();
`else
        chk("lu9_early", regwrite, 0);
        chk("pend9_held", pending[9], 1);
        idle();
        chk("lu9_rw", regwrite, 1);
        chk("lu9_reg", wrreg, 9);
        chk("lu9_data", wrdata, 32'h1234);
        chk("pend9_clr", pending[9], 0);
`endif

        // Same-cycle pipe and LU: pipe first
        issue_valid = 1; issue_reg = 4;
        step();
        issue_valid = 0;
        pipe_we = 1; pipe_reg = 3; pipe_data = 32'hA;
        lu_valid = 1; lu_reg = 4; lu_data = 32'hB;
        step();
        chk("order_first", wrreg, 3);
        idle();
        chk("order_second_rw", regwrite, 1);
        chk("order_second", wrreg, 4);

        // Fill the FIFO under continuous pipe writes, then stall
        for (int i = 0; i < DEPTH; i++) begin
            pipe_we = 0; lu_valid = 0; issue_valid = 1; issue_reg = 5'(10 + i);
            step();
        end
        issue_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            pipe_we = 1; pipe_reg = 5'(20 + i); pipe_data = 32'h100 + i;
            lu_valid = 1; lu_reg = 5'(10 + i); lu_data = 32'h200 + i;
            step();
        end
        lu_valid = 0; pipe_we = 1; pipe_reg = 24; pipe_data = 32'hCAFE;
        #1;
        chk("full_lu_ready", lu_ready, 0);
        chk("full_stall", pipe_stall, 1);
        step();
        chk("full_head", wrreg, 10);
        step();
        chk("held_reg", wrreg, 24);
        chk("held_data", wrdata, 32'hCAFE);
        for (int i = 0; i < DEPTH; i++) idle();

        // $zero traffic never writes or becomes pending
        pipe_we = 1; pipe_reg = 0; pipe_data = 32'h5555;
        step();
        chk("zero_pipe", regwrite, 0);
        pipe_we = 0; issue_valid = 1; issue_reg = 0;
        step();
        chk("zero_pend", pending[0], 0);
        issue_valid = 0; lu_valid = 1; lu_reg = 0; lu_data = 32'h6666;
        step();
        idle();
        chk("zero_lu", regwrite, 0);
        idle();
        chk("zero_lu2", regwrite, 0);
        chk("zero_pend2", pending[0], 0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            pipe_we = 0; lu_valid = 0; issue_valid = 1; issue_reg = 5'(14 + i);
            step();
        end
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1; pipe_reg = 5'(25 + i); pipe_data = $urandom;
            lu_valid = 1; lu_reg = 5'(14 + i); lu_data = $urandom;
            step();
        end
        pipe_we = 0; lu_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_ready", lu_ready, 1);
        chk("arst_regwrite", regwrite, 0);
        reset_model();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) idle();

        // Constrained-random traffic respecting decode's guarantees
        outst.delete();
        last_stall = 0;
        for (int c = 0; c < 400; c++) begin
            if (!last_stall) begin
                pipe_we = ($urandom % 3) == 0;
                cand = $urandom % 9;
                pipe_reg = (cand == 0) ? 5'd0 : 5'(23 + cand);
                pipe_data = $urandom;
            end
            if (outst.size() > 0 && ($urandom % 2) == 0) begin
                idx = $urandom % outst.size();
                lu_valid = 1; lu_reg = 5'(outst[idx]); lu_data = $urandom;
            end else begin
                lu_valid = 0;
            end
            cand = $urandom % 24;
            do_issue = (($urandom % 3) == 0) && !m_pend[cand];
            foreach (outst[k]) if (outst[k] == cand) do_issue = 0;
            issue_valid = do_issue; issue_reg = 5'(cand);
            step();
            if (lu_valid && last_lu_acc) outst.delete(idx);
            if (do_issue) outst.push_back(cand);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
